// File: rtl/rc5_pkg.sv
// rtl/rc5_pkg.sv - RC5-32/12 shared constants, key table, rotate helper and FSM states
package rc5_pkg;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shared with the decryption core so both directions always use identical keys.
    localparam logic [WORD_W-1:0] S [2:25] = '{
        32'h46F8E8C5, 32'h460C6085, 32'h70F83B8A, 32'h284B8303,
        32'h513E1454, 32'hF621ED22, 32'h3125065D, 32'h11A83A5D,
        32'hD427686B, 32'h713AD82D, 32'h4B792F99, 32'h2799A4DD,
        32'hA7901C49, 32'hDEDE871A, 32'h36C03196, 32'hA7EFC249,
        32'h61A78BB8, 32'h3B0A1D2B, 32'h4DBFCA76, 32'hAE162167,
        32'h30D76B0A, 32'h43192304, 32'hF6CC1431, 32'h65046380
    };

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] word,
                                               input logic [4:0]        amt);
        logic [2*WORD_W-1:0] t;
        t = {word, word} << amt;
        return t[2*WORD_W-1:WORD_W];
    endfunction

    // Returns {S[2r], S[2r+1]}; round values outside 1..12 yield zero keys.
    function automatic logic [2*WORD_W-1:0] round_keys(input logic [3:0] rnd);
        logic [2*WORD_W-1:0] keys;
        keys = '0;
        for (int i = 1; i <= ROUNDS; i++) begin
            if (rnd == 4'(i)) begin
                keys = {S[2*i], S[2*i+1]};
            end
        end
        return keys;
    endfunction

endpackage

// File: rtl/rc5_enc_round.sv
// rtl/rc5_enc_round.sv - one combinational RC5 encryption round
module rc5_enc_round
    import rc5_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] ka,
    input  logic [WORD_W-1:0] kb,
    output logic [WORD_W-1:0] a_n,
    output logic [WORD_W-1:0] b_n
);

    // The B half rotates by the freshly computed A, not the registered one.
    always_comb begin
        a_n = rotl(a ^ b, b[4:0]) + ka;
        b_n = rotl(b ^ a_n, a_n[4:0]) + kb;
    end

endmodule

// File: rtl/rc5_encoder.sv
// rtl/rc5_encoder.sv - iterative RC5-32/12 encryptor, one round per clock
module rc5_encoder
    import rc5_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*WORD_W-1:0] d_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*WORD_W-1:0] d_out
);

    state_t              state_q;
    state_t              state_n;
    logic [3:0]          round_q;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic [WORD_W-1:0]   a_n;
    logic [WORD_W-1:0]   b_n;
    logic [2*WORD_W-1:0] keys;
    logic                last_round;

    assign keys       = round_keys(round_q);
    assign last_round = (round_q == 4'(ROUNDS));

    rc5_enc_round u_round (
        .a   (a_q),
        .b   (b_q),
        .ka  (keys[2*WORD_W-1:WORD_W]),
        .kb  (keys[WORD_W-1:0]),
        .a_n (a_n),
        .b_n (b_n)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (last_round) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, capture the final round into d_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_q <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            d_out   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= d_in[2*WORD_W-1:WORD_W];
                        b_q     <= d_in[WORD_W-1:0];
                        round_q <= 4'd1;
                    end
                end
                RUN: begin
                    a_q <= a_n;
                    b_q <= b_n;
                    if (last_round) begin
                        d_out   <= {a_n, b_n};
                        round_q <= 4'd0;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_encoder.sv
// tb/tb_rc5_encoder.sv - self-checking bench for rc5_encoder
module tb_rc5_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] d_out;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rc5_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out)
    );

    localparam logic [31:0] KEY [2:25] = '{
        32'h46F8E8C5, 32'h460C6085, 32'h70F83B8A, 32'h284B8303,
        32'h513E1454, 32'hF621ED22, 32'h3125065D, 32'h11A83A5D,
        32'hD427686B, 32'h713AD82D, 32'h4B792F99, 32'h2799A4DD,
        32'hA7901C49, 32'hDEDE871A, 32'h36C03196, 32'hA7EFC249,
        32'h61A78BB8, 32'h3B0A1D2B, 32'h4DBFCA76, 32'hAE162167,
        32'h30D76B0A, 32'h43192304, 32'hF6CC1431, 32'h65046380
    };

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        return m_rotl(x, (32 - (n % 32)) % 32);
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] pt);
        logic [31:0] a, b;
        a = pt[63:32];
        b = pt[31:0];
        for (int i = 1; i <= 12; i++) begin
            a = m_rotl(a ^ b, int'(b % 32)) + KEY[2*i];
            b = m_rotl(b ^ a, int'(a % 32)) + KEY[2*i+1];
        end
        return {a, b};
    endfunction

    function automatic logic [63:0] m_dec(input logic [63:0] ct);
        logic [31:0] a, b;
        a = ct[63:32];
        b = ct[31:0];
        for (int i = 12; i >= 1; i--) begin
            b = m_rotr(b - KEY[2*i+1], int'(a % 32)) ^ a;
            a = m_rotr(a - KEY[2*i], int'(b % 32)) ^ b;
        end
        return {a, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Entered at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [63:0] pt, output int unsigned t_acc, output bit ok);
        ok = 1'b0;
        t_acc = 0;
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            timeout("send_in_ready");
            return;
        end
        in_valid = 1'b1;
        d_in     = pt;
        @(posedge clk);
        #1 t_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_done(input int start, output int lat, output bit ok);
        lat = start;
        ok  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_out_valid");
    endtask

    task automatic do_block(input logic [63:0] pt, output logic [63:0] ct,
                            output int lat, output int unsigned t_acc, output bit ok);
        bit ok1, ok2;
        ct = '0;
        send(pt, t_acc, ok1);
        ok = 1'b0;
        lat = 0;
        if (!ok1) return;
        wait_done(0, lat, ok2);
        if (!ok2) return;
        ct = d_out;
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
    endtask

    typedef struct {
        logic [63:0] pt;
        logic [63:0] ct;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        logic [63:0] ct, held, x;
        int          lat;
        int unsigned t_acc, t_prev;
        bit          ok;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        d_in      = '0;

        vecs[0].pt = 64'h0000_0000_0000_0000;
        vecs[1].pt = 64'h0000_001B_0000_0000;   // A' = 0 mod 32 in round 1
        vecs[2].pt = 64'h0000_001A_0000_0000;   // A' = 31 mod 32 in round 1
        vecs[3].pt = 64'h0000_0000_0000_001F;   // B rotate amount 31 in round 1
        vecs[4].pt = 64'hFFFF_FFFF_FFFF_FFFF;
        vecs[5].pt = 64'h1234_5678_9ABC_DEF0;
        vecs[6].pt = 64'h8000_0000_0000_0001;
        vecs[7].pt = 64'hDEAD_BEEF_0000_0020;   // B rotate amount 0, nonzero B
        foreach (vecs[i]) vecs[i].ct = m_enc(vecs[i].pt);

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_d_out", d_out, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Known-answer first round and exact latency for an all-zero block
        send(64'd0, t_acc, ok);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            chk("round1_A", 64'(dut.a_q), 64'h46F8E8C5);
            chk("round1_B", 64'(dut.b_q), 64'h2529792D);
            chk("round1_out_valid", 64'(out_valid), 64'd0);
            wait_done(1, lat, ok);
            chk("zero_latency", 64'(lat), 64'd12);
            chk("zero_ct", d_out, m_enc(64'd0));
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("zero_hs_in_ready", 64'(in_ready), 64'd1);
            chk("zero_hs_out_valid", 64'(out_valid), 64'd0);
        end

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_block(vecs[i].pt, ct, lat, t_acc, ok);
            chk($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd12);
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
        end

        // Random back-to-back blocks
        t_prev = 0;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            do_block(x, ct, lat, t_acc, ok);
            chk("rand_ct", ct, m_enc(x));
            chk("rand_roundtrip", m_dec(ct), x);
            if (i > 0) chk("rand_period", 64'(t_acc - t_prev), 64'd14);
            t_prev = t_acc;
        end

        // Output stall with noisy inputs
        out_ready = 1'b0;
        x = 64'h0F1E_2D3C_4B5A_6978;
        send(x, t_acc, ok);
        wait_done(0, lat, ok);
        held = d_out;
        chk("stall_ct", held, m_enc(x));
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'($urandom);
            d_in     = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            chk("stall_d_out", d_out, held);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_rel_out_valid", 64'(out_valid), 64'd0);
        chk("stall_rel_in_ready", 64'(in_ready), 64'd1);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_no_extra", {62'd0, in_ready, out_valid}, 64'd2);
        end

        // in_valid pulsed during RUN must be ignored
        x = 64'h0123_4567_89AB_CDEF;
        send(x, t_acc, ok);
        in_valid = 1'b1;
        d_in     = '1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        d_in     = '0;
        wait_done(4, lat, ok);
        chk("runpulse_lat", 64'(lat), 64'd12);
        chk("runpulse_ct", d_out, m_enc(x));
        @(posedge clk);
        @(negedge clk);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("runpulse_idle", {62'd0, in_ready, out_valid}, 64'd2);
        end

        // Reset while round 6 is pending
        send(64'hCAFE_F00D_1357_9BDF, t_acc, ok);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_d_out", d_out, 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            chk("postrst_quiet", {62'd0, in_ready, out_valid}, 64'd2);
        end
        x = 64'h7654_3210_FEDC_BA98;
        do_block(x, ct, lat, t_acc, ok);
        chk("postrst_ct", ct, m_enc(x));
        chk("postrst_lat", 64'(lat), 64'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/rc5_encoder.md
# rc5_encoder

Iterative RC5-32/12 block encryption core, the transmit-side counterpart of the team's RC5 decryption core (RC5Decoder). It takes one 64-bit plaintext block over a valid/ready handshake and runs 12 rounds, one per clock, with the same fixed round-key table S[2..25]. It returns the 64-bit ciphertext over a second valid/ready handshake. Round trip is exact: feeding d_out into RC5Decoder returns the original d_in. No key whitening with S[0]/S[1] is applied in either direction.

## Interface
- Parameters: none. The round count (12) and the key table are package constants, not overridable.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  d_in carries a plaintext block.
- in_ready  out  1  core can accept a block.
- d_in  in  64  plaintext block; A = d_in[63:32], B = d_in[31:0].
- out_valid  out  1  d_out holds a ciphertext block.
- out_ready  in  1  downstream accepts d_out.
- d_out  out  64  ciphertext block; {A, B} after round 12.

## Operation
- Word arithmetic: 32-bit, addition mod 2^32, no carry out.
- rotl(x, n) rotates x left by n[4:0]. A rotate amount of 0 leaves x unchanged.
- Round i, for i = 1..12, in this order:
  - A' = rotl(A ^ B, B) + S[2i]
  - B' = rotl(B ^ A', A') + S[2i+1]
  - B' uses the new A' within the same cycle.
- Key table S[2..25]: 46F8E8C5 460C6085 70F83B8A 284B8303 513E1454 F621ED22 3125065D 11A83A5D D427686B 713AD82D 4B792F99 2799A4DD A7901C49 DEDE871A 36C03196 A7EFC249 61A78BB8 3B0A1D2B 4DBFCA76 AE162167 30D76B0A 43192304 F6CC1431 65046380.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1, out_valid=0. When in_valid=1, load A/B from d_in, set round=1, go to RUN.
  - RUN: in_ready=0. Apply round `round` each cycle and increment `round`. When round=12, write the round result into d_out and go to DONE.
  - DONE: out_valid=1, d_out held stable. When out_ready=1, go to IDLE.
- Flow control:
  - in_valid is ignored outside IDLE.
  - d_in is sampled only on the accept edge; later changes to d_in have no effect.
  - out_ready is ignored outside DONE.
- Reset, at any time including mid-RUN or DONE:
  - state=IDLE, round=0, A=B=0, d_out=0.
  - in_ready=1 after release, out_valid=0.
  - Any in-flight block is discarded and never emitted.
- Round counter: 4 bits, valid range 1..12. Values 0 and 13..15 are never used as key indices.

## Timing
- in_ready and out_valid are decoded from registered state only. No combinational path from in_valid/out_ready to any output.
- Accept edge T (IDLE with in_valid=1):
  - rounds 1..12 execute on edges T+1..T+12;
  - out_valid rises after edge T+12, so latency is 12 cycles.
- Output handshake completes on the first edge with out_ready=1 in DONE, at T+13 at the earliest. in_ready rises after that edge.
- Back-to-back throughput: one block per 14 cycles. Accepting in the same cycle as the output handshake is not supported.
- out_ready held low: DONE persists indefinitely with d_out stable.

## Structure
- Package rc5_pkg:
  - WORD_W = 32, ROUNDS = 12;
  - localparam key array S[2:25];
  - function rotl(word, amt);
  - state enum {IDLE, RUN, DONE}.
- RC5Decoder shares the package key table, so the two cores cannot drift apart.
- Sub-module rc5_enc_round: purely combinational, one round. Inputs a, b, ka=S[2i], kb=S[2i+1]; outputs a_n, b_n.
- Top level holds the FSM, round counter, A/B registers, output register and key selection by `round`.

## Test plan
- Reset then accept d_in=0 → probe after edge T+1: A=46F8E8C5, B=2529792D. out_valid rises exactly after edge T+12.
- Random 1000 blocks, out_ready=1 → each d_out, passed through RC5Decoder, equals its d_in. Each block takes 14 cycles.
- out_ready held 0 for 20 cycles in DONE, with d_in/in_valid toggling → d_out stable, in_ready=0, no extra accept. Release → one transfer, then in_ready=1.
- in_valid pulsed during RUN with d_in=FFFF…FF → ignored; the result matches the originally accepted block only.
- rst asserted at round 6, then released → out_valid=0, d_out=0, in_ready=1; the aborted block never appears. The next block encrypts correctly.
- Rotate-amount edge cases (B, A' ≡ 0 and ≡ 31 mod 32 at chosen rounds) → match the software model bit-exactly.
